// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined logic/shift unit with valid/ready handshakes on both sides.
// S1 holds the accepted operands; S2 holds the computed result and its flags.
module logic_unit_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    input  logic [3:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SHW = $clog2(WIDTH);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [3:0]       s1_op;

    logic             s2_load;
    logic [SHW-1:0]   amt;
    logic [2*WIDTH-1:0] dbl_l;
    logic [2*WIDTH-1:0] dbl_r;
    logic [WIDTH-1:0] res;
    logic             res_err;

    // S2 only moves when it has something to take or something to give up.
    assign s2_load  = (s1_valid | out_valid) & (!out_valid | out_ready);
    assign in_ready = !s1_valid | s2_load;

    always_comb begin
        amt     = SHW'(32'(s1_b[SHW-1:0]) % WIDTH);
        // Rotates come from the matching half of the operand doubled end to end.
        dbl_l   = {s1_a, s1_a} << amt;
        dbl_r   = {s1_a, s1_a} >> amt;
        res     = '0;
        res_err = 1'b0;
        case (s1_op)
            4'd0:    res = s1_a & s1_b;
            4'd1:    res = s1_a | s1_b;
            4'd2:    res = s1_a ^ s1_b;
            4'd3:    res = ~s1_a;
            4'd4:    res = ~(s1_a & s1_b);
            4'd5:    res = ~(s1_a | s1_b);
            4'd6:    res = ~(s1_a ^ s1_b);
            4'd7:    res = s1_a << amt;
            4'd8:    res = s1_a >> amt;
            4'd9:    res = dbl_l[2*WIDTH-1:WIDTH];
            4'd10:   res = dbl_r[WIDTH-1:0];
            4'd11:   res = s1_a;
            default: begin
                res     = '0;
                res_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= inp1;
                s1_b  <= inp2;
                s1_op <= op;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            flags     <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out   <= res;
                flags <= {res_err, ^res, res[WIDTH-1], res == '0};
            end
        end
    end

endmodule
